ssd_scan_controller: RTL and testbench
======================================

Name: ssd_scan_controller

Overview:
Sequencer for the four-digit seven-segment display. It stores four 4-bit digit values entered one at a time through a single-cycle load strobe. It time-multiplexes those values onto one shared hex-to-segment decoder by scanning the active-low digit enables at a divided refresh rate. A one-cycle all-off guard slot is inserted at every digit change to suppress ghosting. It sits between the debouncer output and the binary-to-segment decoder.

Parameters:
REFRESH_DIV, 50000, clk cycles each digit is displayed (SHOW phase length); legal range 2..2^24; counter width $clog2(REFRESH_DIV).

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
load_pulse  input  1  single-cycle strobe, already debounced; write user_inp into the digit at wr_ptr
clear  input  1  synchronous clear of digit storage and entry state
user_inp  input  4  hex value to store on load_pulse
active_digit  output  4  registered, active-low one-cold digit enable; bit0 = rightmost digit
seg_nibble  output  4  registered hex value for the shared decoder, aligned with active_digit
wr_ptr  output  2  index of the next digit to be written
entry_done  output  1  sticky; set once digit 3 has been written since the last clear/reset

Behaviour:
- Reset (reset=1 at a clk edge) forces:
  - digits d0..d3 = 0; wr_ptr = 0; entry_done = 0
  - scan_idx = 0; prescaler = 0; state = GUARD
  - active_digit = 4'b1111; seg_nibble = 0
  - Reset has priority over all other inputs and aborts any scan or entry mid-operation.
- Entry:
  - On load_pulse, d[wr_ptr] <= user_inp and wr_ptr <= wr_ptr+1 (mod 4, wraps 3->0).
  - Writing at wr_ptr=3 sets entry_done.
  - Further loads after wrap overwrite d0.. and entry_done stays 1.
- clear: same effect as reset on d0..d3, wr_ptr and entry_done only; scan state is untouched.
  - clear has priority over a simultaneous load_pulse, so that load is dropped.
- A held-high load_pulse writes once per cycle. Upstream guarantees single-cycle pulses.
- Scan FSM has two states:
  - GUARD: active_digit = 1111 for exactly 1 cycle, then go to SHOW with prescaler = 0.
  - SHOW: active_digit = ~(4'b0001 << scan_idx) and seg_nibble = d[scan_idx], registered each cycle. The prescaler counts 0..REFRESH_DIV-1.
  - At the terminal count, go to GUARD and set scan_idx <= scan_idx+1 (mod 4).
  - Full digit period = REFRESH_DIV+1 cycles; full frame = 4*(REFRESH_DIV+1) cycles.
- Latency:
  - seg_nibble/active_digit lag the internal state by 1 register stage.
  - After reset deasserts: 1 GUARD cycle, then active_digit = 1110 appears at edge 2.
  - A load into the digit currently shown is visible on seg_nibble 1 cycle after the write edge, with no glitch on active_digit.
- Entry and scanning are independent. A simultaneous load and scan advance both take effect.
- seg_nibble during GUARD holds its previous value (it is don't-care for the display, but must not be X).

Optional Feature:
- Macro: SSD_LEADING_ZERO_BLANK_EN
- When defined:
  - In SHOW, a digit i is blanked (active_digit = 1111) if d[i] == 0 and every higher digit d[j>i] == 0.
  - Digit 0 is never blanked, so the value 0 shows a single "0".
  - Timing and scan sequence are unchanged.
- When undefined: all four digits are always enabled in SHOW.

Decomposition:
- Package ssd_pkg:
  - NUM_DIGITS = 4
  - DIGIT_OFF = 4'b1111
  - scan state enum {GUARD, SHOW}
  - 4-bit digit_t typedef
- Sub-module ssd_refresh_timer:
  - Prescaler with parameter REFRESH_DIV.
  - Inputs clk, reset, restart; output tick asserted on the terminal count.
- The FSM, digit storage and entry logic live in the top.

Test Plan (REFRESH_DIV=4):
- Reset then release -> active_digit 1111 for 1 cycle, then 1110 for 4 cycles, 1111 for 1, 1101 for 4, 1111, 1011, 1111, 0111, back to 1110; seg_nibble = 0 throughout.
- Four load_pulses with user_inp = 1, 2, 3, 4 -> d0..d3 = 1, 2, 3, 4; wr_ptr 0->1->2->3->0; entry_done rises on the 4th load; the scan shows 1 on 1110, 2 on 1101, 3 on 1011, 4 on 0111.
- Fifth load_pulse with user_inp=A -> d0=A, wr_ptr=1, entry_done stays 1.
- clear and load_pulse asserted in the same cycle -> digits 0, wr_ptr 0, entry_done 0, load ignored; scan_idx/prescaler unaffected (scan continues mid-period).
- reset asserted mid-SHOW on digit 2 -> next edge active_digit = 1111, scan restarts at digit 0, all digits 0.
- SSD_LEADING_ZERO_BLANK_EN defined, digits d3..d0 = 0,0,5,0 -> d3 and d2 slots show 1111; d1 shows 5 on 1101; d0 shows 0 on 1110.

Source files
------------

// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ssd_pkg
//  Description : Shared types and constants for the four-digit seven-segment
//                scan controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package ssd_pkg;

    localparam int NUM_DIGITS = 4;
    localparam logic [3:0] DIGIT_OFF = 4'b1111;

    typedef logic [3:0] digit_t;

    typedef enum logic [0:0] {
        GUARD = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // Active-low one-cold enable for the selected digit
    function automatic logic [3:0] digit_enable(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ssd_refresh_timer.sv
`default_nettype none
// ============================================================================
//  Module      : ssd_refresh_timer
//  Description : Refresh prescaler. Counts 0..REFRESH_DIV-1 while restart is
//                low and flags the terminal count with tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module ssd_refresh_timer #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] C_TERM = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] r_count;

    // A restart holds the count at zero so SHOW always begins from a fresh period
    assign tick = !restart && (r_count == C_TERM);

    // Prescaler register: clear on reset, restart or terminal count
    always_ff @(posedge clk) begin
        if (reset || restart || tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ssd_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : ssd_scan_controller
//  Description : Stores four hex digits entered via a load strobe and scans
//                them onto a shared decoder with a one-cycle blank guard slot
//                between digits.
//                Optional: SSD_LEADING_ZERO_BLANK_EN blanks leading zeros.
//  Revision    : 1.0 - initial release
// ============================================================================
module ssd_scan_controller
    import ssd_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_pulse,
    input  logic       clear,
    input  logic [3:0] user_inp,
    output logic [3:0] active_digit,
    output logic [3:0] seg_nibble,
    output logic [1:0] wr_ptr,
    output logic       entry_done
);

    digit_t      r_digits [NUM_DIGITS];
    logic [1:0]  r_wr_ptr;
    logic        r_entry_done;

    scan_state_t r_state;
    scan_state_t w_state_next;
    logic [1:0]  r_scan_idx;
    logic [1:0]  w_scan_idx_next;
    logic [3:0]  r_active_digit;
    logic [3:0]  w_active_digit_next;
    logic [3:0]  r_seg_nibble;
    logic [3:0]  w_seg_nibble_next;
    logic        w_tick;
    logic        w_restart;
    logic        w_blank;

    assign active_digit = r_active_digit;
    assign seg_nibble   = r_seg_nibble;
    assign wr_ptr       = r_wr_ptr;
    assign entry_done   = r_entry_done;

    // Prescaler is held cleared during GUARD so each SHOW lasts REFRESH_DIV cycles
    assign w_restart = (r_state == GUARD);

    ssd_refresh_timer #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .restart (w_restart),
        .tick    (w_tick)
    );

`ifdef SSD_LEADING_ZERO_BLANK_EN
    // w_upper_zero[i]: digit i and every higher digit are zero
    logic [NUM_DIGITS-1:0] w_upper_zero;

    assign w_upper_zero[NUM_DIGITS-1] = (r_digits[NUM_DIGITS-1] == 4'd0);

    generate
        for (genvar gi = 0; gi < NUM_DIGITS - 1; gi++) begin : g_zero_chain
            assign w_upper_zero[gi] = (r_digits[gi] == 4'd0) && w_upper_zero[gi+1];
        end
    endgenerate

    // Digit 0 stays lit so a value of zero still shows one "0"
    assign w_blank = (r_scan_idx != 2'd0) && w_upper_zero[r_scan_idx];
`else
    assign w_blank = 1'b0;
`endif

    // Digit storage and entry pointer; clear wins over a coincident load
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_digits[i] <= '0;
            end
            r_wr_ptr     <= 2'd0;
            r_entry_done <= 1'b0;
        end else if (load_pulse) begin
            r_digits[r_wr_ptr] <= user_inp;
            r_wr_ptr           <= r_wr_ptr + 2'd1;
            if (r_wr_ptr == 2'd3) begin
                r_entry_done <= 1'b1;
            end
        end
    end

    // Scan next-state and next-output logic
    always_comb begin
        w_state_next        = r_state;
        w_scan_idx_next     = r_scan_idx;
        w_active_digit_next = DIGIT_OFF;
        w_seg_nibble_next   = r_seg_nibble;
        case (r_state)
            GUARD: begin
                w_state_next = SHOW;
            end
            SHOW: begin
                w_active_digit_next = w_blank ? DIGIT_OFF : digit_enable(r_scan_idx);
                w_seg_nibble_next   = r_digits[r_scan_idx];
                if (w_tick) begin
                    w_state_next    = GUARD;
                    w_scan_idx_next = r_scan_idx + 2'd1;
                end
            end
            default: begin
                w_state_next = GUARD;
            end
        endcase
    end

    // Scan state and registered display outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= GUARD;
            r_scan_idx     <= 2'd0;
            r_active_digit <= DIGIT_OFF;
            r_seg_nibble   <= 4'd0;
        end else begin
            r_state        <= w_state_next;
            r_scan_idx     <= w_scan_idx_next;
            r_active_digit <= w_active_digit_next;
            r_seg_nibble   <= w_seg_nibble_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ssd_scan_controller
//  Description : Directed self-checking bench for ssd_scan_controller with
//                REFRESH_DIV = 4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ssd_scan_controller;

    localparam int DIV    = 4;
    localparam int PERIOD = DIV + 1;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       load_pulse = 1'b0;
    logic       clear      = 1'b0;
    logic [3:0] user_inp   = 4'd0;
    logic [3:0] active_digit;
    logic [3:0] seg_nibble;
    logic [1:0] wr_ptr;
    logic       entry_done;

    int    total = 0;
    int    bad   = 0;
    int    n     = 0;
    string phase = "reset";

    logic [3:0] mdig [4];
    logic [1:0] mptr  = 2'd0;
    logic       mdone = 1'b0;
    logic [3:0] mseg  = 4'd0;

    ssd_scan_controller #(
        .REFRESH_DIV (DIV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .load_pulse   (load_pulse),
        .clear        (clear),
        .user_inp     (user_inp),
        .active_digit (active_digit),
        .seg_nibble   (seg_nibble),
        .wr_ptr       (wr_ptr),
        .entry_done   (entry_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s/%s observed=%h expected=%h at n=%0d", phase, tag, obs, exp, n);
        end
    endtask

    // One clock: drive inputs, predict outputs from pre-edge model state, compare
    task automatic step(input logic rst, input logic lp, input logic clr, input logic [3:0] val);
        logic [3:0] ead;
        int         p;
        int         di;
        logic       bl;
        reset      = rst;
        load_pulse = lp;
        clear      = clr;
        user_inp   = val;
        ead        = 4'hF;
        if (rst) begin
            mseg = 4'd0;
            n    = 0;
        end else begin
            n  = n + 1;
            p  = (n - 1) % PERIOD;
            di = ((n - 1) / PERIOD) % 4;
            if (p != 0) begin
                ead  = ~(4'b0001 << di);
                mseg = mdig[di];
                bl   = (di != 0);
                for (int j = di; j < 4; j++) begin
                    if (mdig[j] != 4'd0) bl = 1'b0;
                end
`ifdef SSD_LEADING_ZERO_BLANK_EN
                if (bl) ead = 4'hF;
`endif
            end
        end
        if (rst || clr) begin
            for (int j = 0; j < 4; j++) mdig[j] = 4'd0;
            mptr  = 2'd0;
            mdone = 1'b0;
        end else if (lp) begin
            mdig[mptr] = val;
            if (mptr == 2'd3) mdone = 1'b1;
            mptr = mptr + 2'd1;
        end
        @(posedge clk);
        #1;
        check("active_digit", active_digit, ead);
        check("seg_nibble", seg_nibble, mseg);
        check("wr_ptr", {2'b00, wr_ptr}, {2'b00, mptr});
        check("entry_done", {3'b000, entry_done}, {3'b000, mdone});
        reset      = 1'b0;
        load_pulse = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) step(1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    initial begin
        for (int j = 0; j < 4; j++) mdig[j] = 4'd0;

        phase = "reset";
        step(1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 4'd0);

        phase = "idle_scan";
        idle(2 * 4 * PERIOD);

        phase = "load_1234";
        step(1'b0, 1'b1, 1'b0, 4'h1);
        step(1'b0, 1'b1, 1'b0, 4'h2);
        step(1'b0, 1'b1, 1'b0, 4'h3);
        step(1'b0, 1'b1, 1'b0, 4'h4);
        idle(4 * PERIOD + 2);

        phase = "wrap_load";
        step(1'b0, 1'b1, 1'b0, 4'hA);
        idle(6);

        phase = "clear_and_load";
        step(1'b0, 1'b1, 1'b1, 4'h5);
        idle(8);

        phase = "reload";
        step(1'b0, 1'b1, 1'b0, 4'h7);
        step(1'b0, 1'b1, 1'b0, 4'h8);
        step(1'b0, 1'b1, 1'b0, 4'h9);

        // Advance until the last sampled cycle was mid-SHOW on digit 2
        phase = "seek_digit2";
        for (int k = 0; k < 4 * PERIOD; k++) begin
            if ((((n - 1) / PERIOD) % 4 == 2) && ((n - 1) % PERIOD == 2)) break;
            idle(1);
        end
        check("at_digit2", active_digit, 4'b1011);

        phase = "reset_mid_show";
        step(1'b1, 1'b0, 1'b0, 4'd0);
        idle(3 * PERIOD);

        phase = "leading_zero";
        step(1'b0, 1'b1, 1'b0, 4'h0);
        step(1'b0, 1'b1, 1'b0, 4'h5);
        step(1'b0, 1'b1, 1'b0, 4'h0);
        step(1'b0, 1'b1, 1'b0, 4'h0);
        idle(4 * PERIOD + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
